// File: rtl/hilo_mdu_ctrl_if.sv
// Operation encoding and the EX-side handshake bundle for the HI/LO multiply/divide sequencer.
// EX drives operation/operands/flush; the sequencer returns stall and the HI/LO read ports.
package hilo_mdu_pkg;
    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_MADD  = 4'd3,
        OP_MADDU = 4'd4,
        OP_MSUB  = 4'd5,
        OP_MSUBU = 4'd6,
        OP_DIV   = 4'd7,
        OP_DIVU  = 4'd8,
        OP_MTHI  = 4'd9,
        OP_MTLO  = 4'd10,
        OP_MFHI  = 4'd11,
        OP_MFLO  = 4'd12,
        OP_ALU   = 4'd13
    } Oper_t;
endpackage

interface hilo_mdu_ctrl_if;
    import hilo_mdu_pkg::*;
    logic        start;
    Oper_t       op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        flush;
    logic        stall;
    logic [31:0] hi_rdata;
    logic [31:0] lo_rdata;

    modport master (output start, op, rs_data, rt_data, flush,
                    input  stall, hi_rdata, lo_rdata);
    modport slave  (input  start, op, rs_data, rt_data, flush,
                    output stall, hi_rdata, lo_rdata);
endinterface

// File: rtl/hilo_mdu_ctrl.sv
// HI/LO owner: registered multiply-accumulate, restoring radix-2 divider with sign fixup,
// and MTHI/MTLO writes; stalls the pipeline while an operation is in flight.
module hilo_mdu_ctrl
    import hilo_mdu_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 2
) (
    input  logic           clk,
    input  logic           rst,
    hilo_mdu_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MUL  = 3'd1,
        S_DIV  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [1:0] ACC_NONE = 2'd0;
    localparam logic [1:0] ACC_ADD  = 2'd1;
    localparam logic [1:0] ACC_SUB  = 2'd2;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] prod_q, prod_d;
    logic [1:0]  acc_q, acc_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
    logic        qneg_q, qneg_d, rneg_q, rneg_d;

    logic        is_mul_s, is_div_s, op_signed_s, stall_s, qbit_s;
    logic [1:0]  acc_mode_s;
    logic [63:0] ext_a_s, ext_b_s;
    logic [32:0] trial_s, diff_s;
    logic [31:0] step_rem_s;

    function automatic logic [31:0] cond_neg(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

    // Operation class decode
    always_comb begin
        is_mul_s    = 1'b0;
        is_div_s    = 1'b0;
        op_signed_s = 1'b0;
        acc_mode_s  = ACC_NONE;
        case (bus.op)
            OP_MULT:  begin is_mul_s = 1'b1; op_signed_s = 1'b1; end
            OP_MULTU: begin is_mul_s = 1'b1; end
            OP_MADD:  begin is_mul_s = 1'b1; op_signed_s = 1'b1; acc_mode_s = ACC_ADD; end
            OP_MADDU: begin is_mul_s = 1'b1; acc_mode_s = ACC_ADD; end
            OP_MSUB:  begin is_mul_s = 1'b1; op_signed_s = 1'b1; acc_mode_s = ACC_SUB; end
            OP_MSUBU: begin is_mul_s = 1'b1; acc_mode_s = ACC_SUB; end
            OP_DIV:   begin is_div_s = 1'b1; op_signed_s = 1'b1; end
            OP_DIVU:  begin is_div_s = 1'b1; end
            default:  begin is_mul_s = 1'b0; end
        endcase
    end

    // Multiplier operand extension and one restoring-division step
    always_comb begin
        ext_a_s = op_signed_s ? {{32{bus.rs_data[31]}}, bus.rs_data} : {32'd0, bus.rs_data};
        ext_b_s = op_signed_s ? {{32{bus.rt_data[31]}}, bus.rt_data} : {32'd0, bus.rt_data};
        trial_s = {rem_q, quo_q[31]};
        diff_s  = trial_s - {1'b0, dvs_q};
        if (!diff_s[32]) begin
            step_rem_s = diff_s[31:0];
            qbit_s     = 1'b1;
        end else begin
            step_rem_s = trial_s[31:0];
            qbit_s     = 1'b0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            prod_q  <= 64'd0;
            acc_q   <= ACC_NONE;
            rem_q   <= 32'd0;
            quo_q   <= 32'd0;
            dvs_q   <= 32'd0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
        end
    end

    // Next-state and datapath update; a flush drops everything in flight
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        if (bus.flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start && is_mul_s) begin
                        prod_d  = ext_a_s * ext_b_s;
                        acc_d   = acc_mode_s;
                        cnt_d   = 5'(MUL_LATENCY - 1);
                        state_d = S_MUL;
                    end else if (bus.start && is_div_s) begin
                        rem_d   = 32'd0;
                        quo_d   = cond_neg(bus.rs_data, op_signed_s & bus.rs_data[31]);
                        dvs_d   = cond_neg(bus.rt_data, op_signed_s & bus.rt_data[31]);
                        qneg_d  = op_signed_s & (bus.rs_data[31] ^ bus.rt_data[31]);
                        rneg_d  = op_signed_s & bus.rs_data[31];
                        cnt_d   = 5'd31;
                        state_d = S_DIV;
                    end else if (bus.start && (bus.op == OP_MTHI)) begin
                        hi_d = bus.rs_data;
                    end else if (bus.start && (bus.op == OP_MTLO)) begin
                        lo_d = bus.rs_data;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_MUL: begin
                    if (cnt_q == 5'd0) begin
                        case (acc_q)
                            ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                            ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                            default: {hi_d, lo_d} = prod_q;
                        endcase
                        state_d = S_DONE;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_DIV: begin
                    rem_d = step_rem_s;
                    quo_d = {quo_q[30:0], qbit_s};
                    if (cnt_q == 5'd0) begin
                        state_d = S_FIX;
                    end else begin
                        cnt_d = cnt_q - 5'd1;
                    end
                end
                S_FIX: begin
                    lo_d    = cond_neg(quo_q, qneg_q);
                    hi_d    = cond_neg(rem_q, rneg_q);
                    state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Stall covers the issuing cycle too, so the op is held in EX until completion
    always_comb begin
        stall_s = 1'b0;
        if (bus.flush) begin
            stall_s = 1'b0;
        end else begin
            case (state_q)
                S_MUL, S_DIV, S_FIX: stall_s = 1'b1;
                S_IDLE:              stall_s = bus.start & (is_mul_s | is_div_s);
                default:             stall_s = 1'b0;
            endcase
        end
    end

    assign bus.stall    = stall_s;
    assign bus.hi_rdata = hi_q;
    assign bus.lo_rdata = lo_q;
endmodule

// File: tb/tb_hilo_mdu_ctrl.sv
// Scoreboard bench for hilo_mdu_ctrl: a behavioural HI/LO model predicts each result,
// which is queued at issue and compared when stall drops.
module tb_hilo_mdu_ctrl;
    import hilo_mdu_pkg::*;

    localparam int LAT = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hilo_mdu_ctrl_if bus ();
    hilo_mdu_ctrl #(.MUL_LATENCY(LAT)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sb_q[$];

    task automatic idle_inputs();
        bus.start   = 1'b0;
        bus.op      = OP_NOP;
        bus.rs_data = 32'd0;
        bus.rt_data = 32'd0;
        bus.flush   = 1'b0;
    endtask

    task automatic model_op(input Oper_t op, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p, acc, res;
        logic [31:0]     q, r;
        sa = $signed(a);  sb = $signed(b);
        ua = a;           ub = b;
        acc = {m_hi, m_lo};
        res = acc;
        case (op)
            OP_MULT:  res = sa * sb;
            OP_MULTU: res = ua * ub;
            OP_MADD:  begin p = sa * sb; res = acc + p; end
            OP_MADDU: begin p = ua * ub; res = acc + p; end
            OP_MSUB:  begin p = sa * sb; res = acc - p; end
            OP_MSUBU: begin p = ua * ub; res = acc - p; end
            OP_DIV: begin
                if (b == 32'd0) begin
                    q = a[31] ? 32'h1 : 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    p = sa / sb; q = p[31:0];
                    p = sa % sb; r = p[31:0];
                end
                res = {r, q};
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    q = 32'hFFFF_FFFF;
                    r = a;
                end else begin
                    q = a / b;
                    r = a % b;
                end
                res = {r, q};
            end
            default: res = acc;
        endcase
        {m_hi, m_lo} = res;
        sb_q.push_back(res);
    endtask

    task automatic run_op(input Oper_t op, input logic [31:0] a, input logic [31:0] b,
                          input int exp_cyc, input string name);
        int          cyc;
        logic [63:0] exp;
        model_op(op, a, b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = a; bus.rt_data = b;
        #1;
        cyc = (bus.stall === 1'b1) ? 1 : 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.op = OP_NOP;
            #1;
            if (bus.stall !== 1'b1) break;
            cyc++;
        end
        checks++;
        if (cyc != exp_cyc) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d expected %0d", name, cyc, exp_cyc);
        end
        exp = sb_q.pop_front();
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== exp) begin
            errors++;
            $display("FAIL %s hilo: got %h_%h expected %h_%h", name,
                     bus.hi_rdata, bus.lo_rdata, exp[63:32], exp[31:0]);
        end
    endtask

    task automatic move(input Oper_t op, input logic [31:0] val);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.rs_data = val;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL move_stall: got %b expected 0", bus.stall);
        end
        if (op == OP_MTHI) m_hi = val;
        else               m_lo = val;
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NOP;
        #1;
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL move_value: got %h_%h expected %h_%h",
                     bus.hi_rdata, bus.lo_rdata, m_hi, m_lo);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'hFFFF_0000;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata, bus.stall} !== {64'd0, 1'b0}) begin
            errors++;
            $display("FAIL reset: got hi=%h lo=%h stall=%b expected 0/0/0",
                     bus.hi_rdata, bus.lo_rdata, bus.stall);
        end
        m_hi = 32'd0; m_lo = 32'd0;
    endtask

    task automatic test_mult();
        run_op(OP_MULT, 32'hFFFF_FFFD, 32'h0000_0007, 1 + LAT, "mult_neg");
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== 64'hFFFF_FFFF_FFFF_FFEB) begin
            errors++;
            $display("FAIL mult_const: got %h_%h expected FFFFFFFF_FFFFFFEB",
                     bus.hi_rdata, bus.lo_rdata);
        end
    endtask

    task automatic test_mac();
        move(OP_MTHI, 32'h0000_0001);
        move(OP_MTLO, 32'hFFFF_FFFF);
        run_op(OP_MADDU, 32'd2, 32'd3, 1 + LAT, "maddu");
        run_op(OP_MSUB, 32'd1, 32'd6, 1 + LAT, "msub");
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== 64'h0000_0001_FFFF_FFFF) begin
            errors++;
            $display("FAIL msub_const: got %h_%h expected 00000001_FFFFFFFF",
                     bus.hi_rdata, bus.lo_rdata);
        end
    endtask

    task automatic test_div();
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 34, "div_neg");
        run_op(OP_DIVU, 32'h0000_0064, 32'h0000_0007, 34, "divu");
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== 64'h0000_0002_0000_000E) begin
            errors++;
            $display("FAIL divu_const: got %h_%h expected 00000002_0000000E",
                     bus.hi_rdata, bus.lo_rdata);
        end
    endtask

    task automatic test_div_special();
        run_op(OP_DIVU, 32'h1234_5678, 32'h0, 34, "divu_by_zero");
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, "div_overflow");
        run_op(OP_DIV, 32'hFFFF_FFF0, 32'h0, 34, "div_neg_by_zero");
    endtask

    task automatic test_flush();
        move(OP_MTHI, 32'hAAAA_AAAA);
        move(OP_MTLO, 32'h5555_5555);
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_DIV; bus.rs_data = 32'd100; bus.rt_data = 32'd3;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            bus.start = 1'b0; bus.op = OP_NOP;
        end
        bus.flush = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++;
            $display("FAIL flush_stall: got %b expected 0", bus.stall);
        end
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b1; bus.op = OP_MTLO; bus.rs_data = 32'h0000_0042;
        #1;
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata, bus.stall} !== {64'hAAAA_AAAA_5555_5555, 1'b0}) begin
            errors++;
            $display("FAIL flush_hold: got hi=%h lo=%h stall=%b expected AAAAAAAA/55555555/0",
                     bus.hi_rdata, bus.lo_rdata, bus.stall);
        end
        @(negedge clk);
        bus.start = 1'b0; bus.op = OP_NOP;
        #1;
        m_lo = 32'h0000_0042;
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata} !== {m_hi, m_lo}) begin
            errors++;
            $display("FAIL flush_mtlo: got %h_%h expected %h_%h",
                     bus.hi_rdata, bus.lo_rdata, m_hi, m_lo);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MTHI; bus.rs_data = 32'h0000_BEEF;
        @(negedge clk);
        bus.op = OP_MFHI; bus.rs_data = 32'd0;
        #1;
        m_hi = 32'h0000_BEEF;
        checks++;
        if ({bus.hi_rdata, bus.stall} !== {32'h0000_BEEF, 1'b0}) begin
            errors++;
            $display("FAIL b2b_mfhi: got hi=%h stall=%b expected 0000BEEF/0",
                     bus.hi_rdata, bus.stall);
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_rst_mid_mul();
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MULT; bus.rs_data = 32'd5; bus.rt_data = 32'd5;
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        m_hi = 32'd0; m_lo = 32'd0;
        checks++;
        if ({bus.hi_rdata, bus.lo_rdata, bus.stall} !== {64'd0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid_mul: got hi=%h lo=%h stall=%b expected 0/0/0",
                     bus.hi_rdata, bus.lo_rdata, bus.stall);
        end
    endtask

    task automatic test_random();
        Oper_t ops[8] = '{OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_DIV, OP_DIVU};
        Oper_t op;
        for (int i = 0; i < 10; i++) begin
            op = ops[$urandom_range(0, 7)];
            run_op(op, $urandom, (i == 3) ? 32'd0 : $urandom,
                   (op == OP_DIV || op == OP_DIVU) ? 34 : 1 + LAT, "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_mult();
        test_mac();
        test_div();
        test_div_special();
        test_flush();
        test_back_to_back();
        test_rst_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/hilo_mdu_ctrl.md
Name: hilo_mdu_ctrl

Overview:
Multi-cycle multiply/divide sequencer that owns the HI/LO register pair. It sits beside the EX stage and accepts the HI/LO-class operations emitted by the decoders. It runs an iterative divider and a pipelined multiply-accumulate, and asserts a pipeline stall while busy. It also services MTHI/MTLO writes and MFHI/MFLO reads.

Parameters:
MUL_LATENCY, 2, cycles spent in MUL state before the HI/LO write; legal range 1..4.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  EX holds a valid instruction; op/rs_data/rt_data valid
op  in  Oper_t  decoded operation
rs_data  in  32  operand A (dividend / multiplicand / MTHI-MTLO source)
rt_data  in  32  operand B (divisor / multiplier)
flush  in  1  exception/ERET flush; aborts any operation in progress
stall  out  1  pipeline must hold EX and earlier stages
hi_rdata  out  32  current HI (MFHI result)
lo_rdata  out  32  current LO (MFLO result)

Behaviour:
- Reset (clk edge with rst=1): HI=LO=0, state=IDLE, counter=0, stall=0. Reset wins over flush and start.
- States: IDLE, MUL, DIV, FIX, DONE.
- Op classes:
  - Multiply-class: OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU.
  - Divide-class: OP_DIV, OP_DIVU.
  - All other ops are ignored except OP_MTHI and OP_MTLO.
- stall = !flush && (state in {MUL, DIV, FIX} || (state==IDLE && start && op is multiply- or divide-class)). stall is combinational.
- IDLE, start with OP_MTHI/OP_MTLO: write HI/LO from rs_data at the clock edge. No stall. The next cycle reads the new value.
- IDLE, start with multiply-class:
  - Latch operands, signedness and accumulate mode (none/add/sub).
  - Go to MUL with counter=MUL_LATENCY-1.
- MUL: the 64-bit product is computed signed or unsigned per op and registered; the counter decrements each cycle. When counter==0:
  - {HI,LO} <= P for MULT/MULTU.
  - {HI,LO} <= {HI,LO}+P for MADD/MADDU.
  - {HI,LO} <= {HI,LO}-P for MSUB/MSUBU.
  - Arithmetic is mod 2^64; then go to DONE.
  - Total stall cycles = 1 + MUL_LATENCY.
- IDLE, start with divide-class:
  - Latch |rs| and |rt| (or raw values if unsigned), plus the quotient sign (rs[31]^rt[31]) and remainder sign (rs[31]), both forced to 0 for DIVU.
  - Go to DIV with counter=31.
- DIV: one restoring radix-2 step per cycle (shift remainder:quotient left by 1, trial-subtract divisor, set quotient bit). Go to FIX after the counter==0 step.
- FIX: negate the quotient and/or remainder per latched signs, write LO=quotient and HI=remainder, then go to DONE. Total stall cycles = 1 + 32 + 1 = 34.
- Divide by zero: runs the full 34 cycles, with no special case.
  - Unsigned result: LO=FFFFFFFF, HI=rs.
  - Signed result: the natural outcome of the algorithm plus sign fixup, with no trap.
- Signed overflow 80000000 / FFFFFFFF: LO=80000000, HI=00000000.
- DONE: stall=0 for one cycle; start is ignored (the completed instruction is leaving EX). Then go to IDLE. An MTHI/MTLO in DONE is impossible by pipeline construction and is ignored.
- flush:
  - In any state, the next state is IDLE with HI/LO unchanged, and an in-flight result is discarded.
  - A start in the same cycle as flush is ignored.
- hi_rdata/lo_rdata: continuous register outputs. MFHI/MFLO behind a busy op is covered by stall.

Test Plan:
- Reset, then MULT rs=FFFFFFFD (-3), rt=00000007 with MUL_LATENCY=2 -> stall high exactly 3 cycles; HI=FFFFFFFF, LO=FFFFFFEB; stall low in DONE.
- MTHI 00000001, MTLO FFFFFFFF, then MADDU 2*3 -> HI=00000002, LO=00000005; then MSUB rs=1, rt=6 -> HI=00000001, LO=FFFFFFFF.
- DIV rs=FFFFFFF9 (-7), rt=00000002 -> stall exactly 34 cycles; LO=FFFFFFFD, HI=FFFFFFFF. Then DIVU 00000064/00000007 -> LO=0000000E, HI=00000002.
- DIVU rs=12345678, rt=0 -> LO=FFFFFFFF, HI=12345678. DIV 80000000/FFFFFFFF -> LO=80000000, HI=0.
- Start DIV (preset HI=AAAAAAAA, LO=55555555), assert flush on DIV cycle 10 -> stall low that cycle; state IDLE; HI/LO unchanged; an MTLO 00000042 the next cycle is accepted.
- Back-to-back MTHI 0000BEEF then MFHI -> hi_rdata=0000BEEF in the cycle after the write with no stall. rst asserted mid-MUL -> HI=LO=0, stall=0 the next cycle.
